// File: rtl/leaf_pkg.sv
// Shared types and helpers for the leaf stream bridge: start-sequencer states,
// default widths and the ap_hs transfer rule.
`ifndef LEAF_AP_HS_XFER
`define LEAF_AP_HS_XFER(vld, ack) ((vld) && (ack))
`endif

package leaf_pkg;

  localparam int PAYLOAD_BITS_DEF = 32;
  localparam int CNT_BITS_DEF     = 32;

  typedef enum logic {
    START_WAIT = 1'b0,
    START_RUN  = 1'b1
  } start_state_e;

  // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A word moves on an ap_hs pair only in a cycle where both sides are high.
  function automatic logic hs_xfer(input logic vld, input logic ack);
    return vld && ack;
  endfunction

endpackage

// File: rtl/leaf_fwft_fifo.sv
// First-word-fall-through FIFO with ap_hs style ports. A word written in one
// cycle is presented on rd_data the next; a full FIFO refuses writes even when read.
module leaf_fwft_fifo
  import leaf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PAYLOAD_BITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  input  logic             rd_ack
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = occ_w(DEPTH);
  localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full   = (occ == FULL_OCC);
  assign rd_vld = (occ != '0);
  assign wr_ack = !full && !flush && !reset;
  assign do_wr  = hs_xfer(wr_vld, wr_ack);
  // Flush wins over a concurrent read: the head word is dropped, not delivered.
  assign do_rd  = hs_xfer(rd_vld, rd_ack) && !flush;

  // Data is forced to zero while nothing is presented so stale words never leak.
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides what is
  // valid, which keeps the array mappable to plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Elastic bridge between leaf_interface vectors and an HLS kernel's ap_hs ports:
// one FWFT FIFO per channel, delayed ap_start, flush and saturating transfer counters.
module leaf_stream_bridge
  import leaf_pkg::*;
#(
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 1,
  parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_DELAY   = 16,
  parameter int CNT_BITS      = CNT_BITS_DEF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]      dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                   vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                   ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]      kin_data,
  output logic [NUM_IN_PORTS-1:0]                   kin_vld,
  input  logic [NUM_IN_PORTS-1:0]                   kin_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]     kout_data,
  input  logic [NUM_OUT_PORTS-1:0]                  kout_vld,
  output logic [NUM_OUT_PORTS-1:0]                  kout_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]     din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                  vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                  ack_interface2user,
  output logic                                      ap_start,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0] xfer_cnt
);

  localparam int NUM_CH = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int DW     = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY);

  // ---------------------------------------------------------------- start sequencer
  start_state_e state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START_WAIT;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      START_WAIT: begin
        if (dly_q == DLY_LAST) state_d = START_RUN;
        else                   dly_d   = dly_q + DW'(1);
      end
      START_RUN: state_d = START_RUN;
      default:   state_d = START_WAIT;
    endcase
  end

  assign ap_start = (state_q == START_RUN);

  // ---------------------------------------------------------------- channel FIFOs
  logic [NUM_CH-1:0]       up_xfer;
  logic [NUM_IN_PORTS-1:0] in_rd_vld;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    // Kernel side is held off until ap_start, but the FIFO keeps filling.
    leaf_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wr_data (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld  (vld_interface2user[i]),
      .wr_ack  (ack_user2interface[i]),
      .rd_data (kin_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld  (in_rd_vld[i]),
      .rd_ack  (kin_ack[i] && ap_start)
    );

    assign kin_vld[i] = in_rd_vld[i] && ap_start;
    assign up_xfer[i] = hs_xfer(vld_interface2user[i], ack_user2interface[i]);
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    leaf_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wr_data (kout_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld  (kout_vld[j]),
      .wr_ack  (kout_ack[j]),
      .rd_data (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld  (vld_user2interface[j]),
      .rd_ack  (ack_interface2user[j])
    );

    assign up_xfer[NUM_IN_PORTS + j] = hs_xfer(kout_vld[j], kout_ack[j]);
  end

  // ---------------------------------------------------------------- transfer counters
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    logic [CNT_BITS-1:0] cnt_q;

    // Counts stick at all-ones; flush leaves them alone, only reset clears.
    always_ff @(posedge clk) begin
      if (reset)                          cnt_q <= '0;
      else if (up_xfer[c] && cnt_q != '1) cnt_q <= cnt_q + CNT_BITS'(1);
    end

    assign xfer_cnt[c*CNT_BITS +: CNT_BITS] = cnt_q;
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Self-checking bench for leaf_stream_bridge: queue-based channel model compared
// every cycle, directed scenarios with literal expectations, and random streaming.
module tb_leaf_stream_bridge;

  localparam int NI   = 2;
  localparam int NO   = 1;
  localparam int P    = 32;
  localparam int D    = 4;
  localparam int SD   = 16;
  localparam int CB   = 4;
  localparam int NCH  = NI + NO;
  localparam int CMAX = (1 << CB) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [NI*P-1:0]   dout_leaf_interface2user;
  logic [NI-1:0]     vld_interface2user;
  logic [NI-1:0]     ack_user2interface;
  logic [NI*P-1:0]   kin_data;
  logic [NI-1:0]     kin_vld;
  logic [NI-1:0]     kin_ack;
  logic [NO*P-1:0]   kout_data;
  logic [NO-1:0]     kout_vld;
  logic [NO-1:0]     kout_ack;
  logic [NO*P-1:0]   din_leaf_user2interface;
  logic [NO-1:0]     vld_user2interface;
  logic [NO-1:0]     ack_interface2user;
  logic              ap_start;
  logic [NCH*CB-1:0] xfer_cnt;

  leaf_stream_bridge #(
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .PAYLOAD_BITS  (P),
    .FIFO_DEPTH    (D),
    .START_DELAY   (SD),
    .CNT_BITS      (CB)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .flush                    (flush),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .kin_data                 (kin_data),
    .kin_vld                  (kin_vld),
    .kin_ack                  (kin_ack),
    .kout_data                (kout_data),
    .kout_vld                 (kout_vld),
    .kout_ack                 (kout_ack),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
    .ack_interface2user       (ack_interface2user),
    .ap_start                 (ap_start),
    .xfer_cnt                 (xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: one ordered queue per channel (inputs first), counts,
  // and the number of edges seen since reset was last sampled high.
  logic [P-1:0] mq [NCH][$];
  int           mcnt [NCH];
  int           rel_edges = 0;
  int           rst_edges = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model for the current cycle, then apply the
  // transfers that the coming edge will perform.
  task automatic model_cycle();
    logic              exp_ap;
    logic [NCH-1:0]    up_ack;
    logic [NCH-1:0]    dn_vld;
    logic [NCH*CB-1:0] e_cnt;
    exp_ap = (rel_edges > SD);
    for (int c = 0; c < NCH; c++) begin
      up_ack[c] = !reset && !flush && (mq[c].size() < D);
      dn_vld[c] = (mq[c].size() > 0) && (c >= NI || exp_ap);
      e_cnt[c*CB +: CB] = CB'(mcnt[c]);
    end
    check("ap_start", ap_start, exp_ap);
    check("ack_user2interface", ack_user2interface, up_ack[NI-1:0]);
    check("kout_ack", kout_ack, up_ack[NCH-1:NI]);
    check("kin_vld", kin_vld, dn_vld[NI-1:0]);
    check("vld_user2interface", vld_user2interface, dn_vld[NCH-1:NI]);
    check("xfer_cnt", xfer_cnt, e_cnt);
    for (int i = 0; i < NI; i++)
      if (dn_vld[i]) check($sformatf("kin_data%0d", i), kin_data[i*P +: P], mq[i][0]);
    for (int j = 0; j < NO; j++)
      if (dn_vld[NI+j]) check($sformatf("din%0d", j), din_leaf_user2interface[j*P +: P], mq[NI+j][0]);
    if (rst_edges > 0) begin
      check("kin_data_zero_in_reset", kin_data, '0);
      check("din_zero_in_reset", din_leaf_user2interface, '0);
    end

    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        mcnt[c] = 0;
      end
      rel_edges = 0;
      rst_edges++;
    end else begin
      rst_edges = 0;
      rel_edges++;
      if (flush) begin
        for (int c = 0; c < NCH; c++) mq[c].delete();
      end else begin
        for (int c = 0; c < NCH; c++) begin
          logic         dn_ack;
          logic         up_vld;
          logic [P-1:0] up_data;
          if (c < NI) begin
            up_vld  = vld_interface2user[c];
            up_data = dout_leaf_interface2user[c*P +: P];
            dn_ack  = kin_ack[c];
          end else begin
            up_vld  = kout_vld[c-NI];
            up_data = kout_data[(c-NI)*P +: P];
            dn_ack  = ack_interface2user[c-NI];
          end
          if (dn_vld[c] && dn_ack) void'(mq[c].pop_front());
          if (up_vld && up_ack[c]) begin
            mq[c].push_back(up_data);
            if (mcnt[c] < CMAX) mcnt[c]++;
          end
        end
      end
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_idle();
    flush                    = 1'b0;
    dout_leaf_interface2user = '0;
    vld_interface2user       = '0;
    kin_ack                  = '0;
    kout_data                = '0;
    kout_vld                 = '0;
    ack_interface2user       = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P-1:0] got [$];
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    reset = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    step(4);

    // ap_start delay: low after edges 0..15, high from edge 16
    reset = 1'b0;
    for (int e = 0; e < 18; e++) begin
      step(1);
      if (e == 15 || e == 16) check($sformatf("ap_start_after_edge%0d", e), ap_start, 1'(e >= SD));
    end

    // channel 0 fills with kernel stalled, then drains in order
    for (int w = 1; w <= 4; w++) begin
      vld_interface2user[0]           = 1'b1;
      dout_leaf_interface2user[P-1:0] = P'(w);
      step(1);
    end
    check("ch0_ack_when_full", ack_user2interface[0], 1'b0);
    dout_leaf_interface2user[P-1:0] = P'(5);
    step(1);
    vld_interface2user[0] = 1'b0;
    kin_ack[0]            = 1'b1;
    got.delete();
    for (int k = 0; k < 10 && got.size() < 4; k++) begin
      if (kin_vld[0]) got.push_back(kin_data[P-1:0]);
      step(1);
    end
    check("ch0_drain_words", got.size(), 4);
    for (int k = 0; k < got.size(); k++) check($sformatf("ch0_word%0d", k), got[k], k + 1);
    check("ch0_xfer_cnt", xfer_cnt[CB-1:0], 4'd4);
    kin_ack[0] = 1'b0;

    // flush with three words buffered on channel 1
    for (int w = 0; w < 3; w++) begin
      vld_interface2user[1]             = 1'b1;
      dout_leaf_interface2user[2*P-1:P] = 32'hA0 + P'(w);
      step(1);
    end
    flush      = 1'b1;
    kin_ack[1] = 1'b1;
    step(1);
    flush                 = 1'b0;
    kin_ack[1]            = 1'b0;
    vld_interface2user[1] = 1'b0;
    check("ch1_vld_after_flush", kin_vld[1], 1'b0);
    check("ch1_cnt_after_flush", xfer_cnt[2*CB-1:CB], 4'd3);
    check("ap_start_after_flush", ap_start, 1'b1);
    step(2);

    // output channel full: simultaneous read refuses the write for one cycle
    for (int w = 0; w < 4; w++) begin
      kout_vld  = 1'b1;
      kout_data = 32'hB0 + P'(w);
      step(1);
    end
    check("out_ack_when_full", kout_ack, 1'b0);
    check("out_head_when_full", din_leaf_user2interface, 32'hB0);
    ack_interface2user = 1'b1;
    kout_data          = 32'hB4;
    step(1);
    check("out_ack_after_read", kout_ack, 1'b1);
    check("out_head_after_read", din_leaf_user2interface, 32'hB1);
    ack_interface2user = 1'b0;
    step(1);
    kout_vld           = 1'b0;
    ack_interface2user = 1'b1;
    got.delete();
    for (int k = 0; k < 10 && got.size() < 4; k++) begin
      if (vld_user2interface[0]) got.push_back(din_leaf_user2interface);
      step(1);
    end
    check("out_drain_words", got.size(), 4);
    for (int k = 0; k < got.size(); k++) check($sformatf("out_word%0d", k), got[k], 32'hB1 + k);
    check("out_xfer_cnt", xfer_cnt[3*CB-1:2*CB], 4'd5);
    set_idle();

    // random streaming on every channel; rare flushes only in the second half
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NI; i++) begin
        vld_interface2user[i]          = ($urandom_range(0, 3) != 0);
        dout_leaf_interface2user[i*P +: P] = $urandom;
        kin_ack[i]                     = $urandom_range(0, 1) == 1;
      end
      kout_vld           = $urandom_range(0, 1) == 1;
      kout_data          = $urandom;
      ack_interface2user = $urandom_range(0, 1) == 1;
      flush              = (t >= 400) && ($urandom_range(0, 31) == 0);
      step(1);
    end
    set_idle();
    kin_ack            = '1;
    ack_interface2user = '1;
    step(8);
    check("drained_kin_vld", kin_vld, '0);
    check("drained_out_vld", vld_user2interface, '0);

    // counter saturation after 20 transfers, then reset mid-stream
    set_idle();
    reset = 1'b1;
    step(2);
    reset              = 1'b0;
    kout_vld           = 1'b1;
    ack_interface2user = 1'b1;
    vld_interface2user = '1;
    kin_ack            = '1;
    for (int t = 0; t < 20; t++) begin
      kout_data                = $urandom;
      dout_leaf_interface2user = {$urandom, $urandom};
      step(1);
      if (t == 13) check("out_cnt_after_14", xfer_cnt[3*CB-1:2*CB], 4'd14);
      if (t == 19) check("out_cnt_saturated", xfer_cnt[3*CB-1:2*CB], 4'hF);
    end
    reset = 1'b1;
    step(1);
    check("reset_all_outputs_zero",
          {ack_user2interface, kin_vld, kin_data, kout_ack, din_leaf_user2interface,
           vld_user2interface, ap_start, xfer_cnt}, '0);
    step(2);
    reset = 1'b0;
    set_idle();
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
